quant_out_writeback: RTL
========================

# quant_out_writeback

Downstream consumer of the 32-lane requantize stage. It captures each 256-bit quantized vector (32 × int8) on the cycle it is presented and buffers it in a small FIFO. It tags each vector with a strided output-buffer address and drains it to the activation SRAM over a valid/ready write port. The requantize stage has no backpressure, so this block absorbs SRAM stalls and flags any beat it cannot hold.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries of {addr, data}; power of two, ≥2
- ADDR_W, 16, SRAM word-address width

Ports:
- CLK  in  1  single clock, rising edge
- RESETn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_*; honoured only in IDLE
- cfg_base_addr  in  ADDR_W  address of first beat
- cfg_stride  in  ADDR_W  address increment per beat
- cfg_num_beats  in  ADDR_W  beats expected in this job
- in_q  in  256  quantized vector (requantize out_q)
- in_valid  in  1  beat present (requantize out_valid)
- mem_wr_valid  out  1  write request
- mem_wr_ready  in  1  SRAM accepts write
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  256  write data
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job completion
- overflow  out  1  sticky: a beat was dropped or arrived outside RUN

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start with cfg_num_beats≠0.
  - IDLE→DONE on start with cfg_num_beats=0.
  - RUN→FLUSH in the cycle the last expected beat is consumed.
  - FLUSH→DONE when the FIFO is empty and no write is outstanding.
  - DONE→IDLE unconditionally; done=1 only in DONE.
- In RUN, each in_valid beat consumes one slot:
  - Remaining-beat counter decrements.
  - Address register advances by cfg_stride, modulo 2^ADDR_W.
  - The first beat uses cfg_base_addr.
- Push rule: a beat is pushed when FIFO occupancy < FIFO_DEPTH or a pop occurs in the same cycle.
  - Otherwise the beat is dropped and overflow is set.
  - A dropped beat still decrements the counter and advances the address, so the job always terminates and later beats keep their correct addresses.
- in_valid outside RUN is not counted and sets overflow. This includes the start cycle itself, FLUSH, and DONE.
- overflow is cleared by start. If a set event occurs in the same cycle, set wins.
- mem_wr_valid = FIFO non-empty; mem_wr_addr and mem_wr_data come from the FIFO head.
  - A pop occurs when mem_wr_valid && mem_wr_ready.
  - Head data and address hold stable while valid && !ready.
- start while busy is ignored, and cfg_* are not re-latched.

## Timing
- Reset values: mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, overflow=0. FSM is in IDLE, FIFO is empty, counters are 0.
- Reset mid-job discards FIFO contents, and no done is emitted.
- Latency: beat at cycle t into an empty FIFO → mem_wr_valid=1 at t+1. Throughput is 1 beat/cycle with mem_wr_ready=1.
- start at t → busy=1 at t+1; the first beat can be accepted at t+1.
- With num_beats=0: start at t → done at t+1 → IDLE at t+2.
- done asserts the cycle after the final pop. busy stays high through DONE.

## Configuration
- QWB_PERF_EN defined: adds two output ports, both cleared on start and on reset.
  - perf_stall_cycles, out, 32: saturating count of cycles with mem_wr_valid && !mem_wr_ready.
  - perf_drop_cnt, out, 16: saturating count of dropped beats, counting FIFO-full drops only.
- QWB_PERF_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package quant_pkg contains:
  - Q_LANES=32, Q_BITS=8, Q_VEC_W=Q_LANES*Q_BITS=256.
  - The qwb_state_t enum {IDLE, RUN, FLUSH, DONE}.
- One sub-module, qwb_fifo:
  - Synchronous FIFO of width ADDR_W+256 and depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, head, and an occupancy count.
  - Asynchronous active-low reset.
- FSM, counters, address generator and the optional perf counters live in the top level.

## Test plan
- Basic job: base=0x0100, stride=2, num_beats=4, four back-to-back beats, ready=1 → writes at 0x0100/0x0102/0x0104/0x0106 with matching data, then done exactly once, then busy=0.
- Stall: num_beats=8, DEPTH=4, ready=0 for 10 cycles while 8 consecutive beats arrive → first 4 stored, beats 5–8 dropped, overflow=1. Drained writes carry addresses of beats 1–4 only; job completes with done.
- Same-cycle push/pop at full: FIFO full, ready=1 and in_valid=1 in the same cycle → beat accepted, overflow stays 0.
- Stray beats: in_valid during IDLE, in the start cycle, and after the last beat → overflow=1, no extra writes, beat count unaffected.
- Edge cases:
  - num_beats=0 → done at start+1, no writes.
  - Address wrap: base=0xFFFE, stride=1, 3 beats → 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-job: deassert RESETn with 2 entries queued → all outputs at reset values immediately; no further writes or done after release. With QWB_PERF_EN, perf counters also read 0.

Source files
------------

// File: rtl/quant_pkg.sv
// ============================================================================
// quant_pkg : shared widths and writeback FSM state type for the quantize path
// Revision  : 1.0
// ============================================================================
`default_nettype none

package quant_pkg;

    localparam int Q_LANES = 32;
    localparam int Q_BITS  = 8;
    localparam int Q_VEC_W = Q_LANES * Q_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } qwb_state_t;

endpackage

`default_nettype wire

// File: rtl/qwb_fifo.sv
// ============================================================================
// qwb_fifo : synchronous FIFO holding {addr, data} entries for the writeback
// Revision : 1.0
// ============================================================================
`default_nettype none

module qwb_fifo #(
    parameter int WIDTH = 272,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is cleared so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/quant_out_writeback.sv
// ============================================================================
// quant_out_writeback : buffers requantized vectors and writes them to SRAM
//                       at strided addresses. Optional: QWB_PERF_EN.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module quant_out_writeback
    import quant_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [ADDR_W-1:0]  cfg_stride,
    input  logic [ADDR_W-1:0]  cfg_num_beats,
    input  logic [Q_VEC_W-1:0] in_q,
    input  logic               in_valid,
    output logic               mem_wr_valid,
    input  logic               mem_wr_ready,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [Q_VEC_W-1:0] mem_wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow
`ifdef QWB_PERF_EN
   ,output logic [31:0]        perf_stall_cycles,
    output logic [15:0]        perf_drop_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ADDR_W + Q_VEC_W;

    qwb_state_t        state;
    qwb_state_t        state_nxt;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] stride;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic              start_ok;
    logic              beat;
    logic              push;
    logic              pop;
    logic              drop;
    logic              stray;
    logic              last_beat;

    assign start_ok  = start && (state == IDLE);
    assign beat      = in_valid && (state == RUN);
    assign pop       = !fifo_empty && mem_wr_ready;
    assign push      = beat && (!fifo_full || pop);
    assign drop      = beat && !push;
    assign stray     = in_valid && (state != RUN);
    assign last_beat = beat && (remaining == ADDR_W'(1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:  if (start) state_nxt = (cfg_num_beats == '0) ? DONE : RUN;
            RUN:   if (last_beat) state_nxt = FLUSH;
            // Leave as soon as the final pop lands so done follows it directly.
            FLUSH: if (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Dropped beats still advance address and count so later beats stay aligned.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            remaining <= '0;
            next_addr <= '0;
            stride    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (start_ok) begin
                remaining <= cfg_num_beats;
                next_addr <= cfg_base_addr;
                stride    <= cfg_stride;
            end else if (beat) begin
                remaining <= remaining - 1'b1;
                next_addr <= next_addr + stride;
            end
            if (stray || drop) begin
                overflow <= 1'b1;
            end else if (start_ok) begin
                overflow <= 1'b0;
            end
        end
    end

    qwb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESETn),
        .push    (push),
        .pop     (pop),
        .wr_data ({next_addr, in_q}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    assign mem_wr_valid = !fifo_empty;
    assign mem_wr_addr  = fifo_head[ENT_W-1 -: ADDR_W];
    assign mem_wr_data  = fifo_head[Q_VEC_W-1:0];

`ifdef QWB_PERF_EN
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            perf_stall_cycles <= '0;
            perf_drop_cnt     <= '0;
        end else if (start_ok) begin
            perf_stall_cycles <= '0;
            perf_drop_cnt     <= '0;
        end else begin
            if (mem_wr_valid && !mem_wr_ready && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (drop && (perf_drop_cnt != '1)) begin
                perf_drop_cnt <= perf_drop_cnt + 1'b1;
            end
        end
    end
`else
    // Build without performance counters: no extra state.
`endif

endmodule

`default_nettype wire
